// File: rtl/arbitro_rr_sched.sv
// Round-robin scheduler: moves one word per cycle from four input FIFOs
// to the output FIFO selected by the word's top two bits.
module arbitro_rr_sched #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    input  logic [3:0]            empty_p,
    input  logic [3:0]            almostfull_p,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [DATA_WIDTH-1:0] data_in3,
    output logic [3:0]            pop_p,
    output logic [3:0]            push_p,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            state,
    output logic                  idle,
    output logic [CNT_WIDTH-1:0]  words_sent
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_INIT   = 2'b01,
        ST_IDLE   = 2'b10,
        ST_ACTIVE = 2'b11
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            last_q;
    logic                  grant_vld;
    logic [1:0]            grant_idx;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [1:0]            dest;
    logic [3:0]            dest_onehot;
    logic                  eligible;

    assign state = state_q;

    // Round-robin search starting after the last granted port.
    always_comb begin
        logic [1:0] cand;
        pop_p     = 4'b0000;
        grant_vld = 1'b0;
        grant_idx = last_q;
        cand      = last_q;
        eligible  = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) &&
                    !init && (almostfull_p == 4'b0000);
        if (eligible) begin
            for (int i = 1; i <= 4; i++) begin
                cand = last_q + 2'(i);
                if (!grant_vld && !empty_p[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_vld) begin
            pop_p[grant_idx] = 1'b1;
        end
    end

    // Head word of the granted port and its destination strobe.
    always_comb begin
        sel_data = data_in0;
        case (grant_idx)
            2'd0:    sel_data = data_in0;
            2'd1:    sel_data = data_in1;
            2'd2:    sel_data = data_in2;
            default: sel_data = data_in3;
        endcase
        dest        = sel_data[DATA_WIDTH-1 -: 2];
        dest_onehot = 4'b0001 << dest;
    end

    // Controller next state; init overrides everything except RESET.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (!init) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (init) begin
                    state_d = ST_INIT;
                end else if ((empty_p != 4'hF) && (almostfull_p == 4'b0000)) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (init) begin
                    state_d = ST_INIT;
                end else if ((empty_p == 4'hF) && (push_p == 4'b0000)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    // Controller state register and idle flag.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_RESET;
            idle    <= 1'b0;
        end else begin
            state_q <= state_d;
            idle    <= (state_d == ST_IDLE) && !grant_vld;
        end
    end

    // Datapath: register popped word, push it next cycle, track rotation.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push_p   <= 4'b0000;
            data_out <= '0;
            last_q   <= 2'd3;
        end else begin
            if (grant_vld) begin
                push_p   <= dest_onehot;
                data_out <= sel_data;
                last_q   <= grant_idx;
            end else begin
                push_p <= 4'b0000;
                if (state_q == ST_INIT) begin
                    last_q <= 2'd3;
                end
            end
        end
    end

    // Wrapping count of completed pushes, cleared while in INIT.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            words_sent <= '0;
        end else if (state_q == ST_INIT) begin
            words_sent <= '0;
        end else if (push_p != 4'b0000) begin
            words_sent <= words_sent + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_arbitro_rr_sched.sv
// Self-checking bench for arbitro_rr_sched: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_arbitro_rr_sched;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        init;
    logic [3:0]  empty_p;
    logic [3:0]  almostfull_p;
    logic [9:0]  data_in0, data_in1, data_in2, data_in3;
    logic [3:0]  pop_p;
    logic [3:0]  push_p;
    logic [9:0]  data_out;
    logic [1:0]  state;
    logic        idle;
    logic [15:0] words_sent;

    int total = 0;
    int bad   = 0;

    // Reference model state (state codes: 0 reset, 1 init, 2 idle, 3 active).
    int          m_state;
    int          m_last;
    logic [3:0]  m_push;
    logic [9:0]  m_data;
    logic        m_idle;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    arbitro_rr_sched #(.DATA_WIDTH(10), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .init         (init),
        .empty_p      (empty_p),
        .almostfull_p (almostfull_p),
        .data_in0     (data_in0),
        .data_in1     (data_in1),
        .data_in2     (data_in2),
        .data_in3     (data_in3),
        .pop_p        (pop_p),
        .push_p       (push_p),
        .data_out     (data_out),
        .state        (state),
        .idle         (idle),
        .words_sent   (words_sent)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_last  = 3;
        m_push  = 4'b0000;
        m_data  = 10'h000;
        m_idle  = 1'b0;
        m_cnt   = 16'h0000;
    endtask

    // One clock: inputs already driven at the falling edge; check grant,
    // advance model at the rising edge, then check registered outputs.
    task automatic step();
        logic [9:0] d [4];
        int         g;
        int         ns;
        d[0] = data_in0; d[1] = data_in1; d[2] = data_in2; d[3] = data_in3;
        #1;
        g = -1;
        if ((m_state == 2 || m_state == 3) && !init && almostfull_p == 4'b0000) begin
            for (int i = 1; i <= 4; i++) begin
                int k;
                k = (m_last + i) % 4;
                if (g < 0 && !empty_p[k]) g = k;
            end
        end
        chk("pop", 32'(pop_p), (g < 0) ? 32'd0 : (32'd1 << g));
        if (m_state == 0)                         ns = 1;
        else if (init)                            ns = 1;
        else if (m_state == 1)                    ns = 2;
        else if (m_state == 2)                    ns = (empty_p != 4'hF && almostfull_p == 4'b0000) ? 3 : 2;
        else                                      ns = (empty_p == 4'hF && m_push == 4'b0000) ? 2 : 3;
        @(posedge clk);
        if (m_state == 1)              m_cnt = 16'h0000;
        else if (m_push != 4'b0000)    m_cnt = m_cnt + 16'd1;
        if (g >= 0) begin
            m_push = 4'b0001 << d[g][9:8];
            m_data = d[g];
            m_last = g;
        end else begin
            m_push = 4'b0000;
            if (m_state == 1) m_last = 3;
        end
        m_state = ns;
        m_idle  = (ns == 2) && (m_push == 4'b0000);
        #1;
        chk("push",  32'(push_p),     32'(m_push));
        chk("data",  32'(data_out),   32'(m_data));
        chk("state", 32'(state),      32'(m_state));
        chk("idle",  32'(idle),       32'(m_idle));
        chk("count", 32'(words_sent), 32'(m_cnt));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        init = 1'b1; empty_p = 4'hF; almostfull_p = 4'h0;
        model_reset();
        #1;
        chk("rst_push",  32'(push_p),     32'd0);
        chk("rst_state", 32'(state),      32'd0);
        chk("rst_data",  32'(data_out),   32'd0);
        chk("rst_cnt",   32'(words_sent), 32'd0);
        chk("rst_idle",  32'(idle),       32'd0);
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        logic [9:0] q [$];
        logic [3:0] exp_push [3];
        reset_L = 1'b1; init = 1'b1; empty_p = 4'hF; almostfull_p = 4'h0;
        data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // 1: reset -> init -> idle
        init = 1'b1;
        step();
        chk("t1_init", 32'(state), 32'd1);
        step();
        init = 1'b0;
        step();
        chk("t1_state", 32'(state), 32'd2);
        chk("t1_idle",  32'(idle),  32'd1);

        // 2: only p2 holds three words
        q = '{10'h1AA, 10'h055, 10'h2F0};
        exp_push[0] = 4'b0010; exp_push[1] = 4'b0001; exp_push[2] = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            empty_p  = (q.size() != 0) ? 4'b1011 : 4'hF;
            data_in2 = (q.size() != 0) ? q[0] : 10'h000;
            step();
            if (i < 3) chk("t2_push", 32'(push_p), 32'(exp_push[i]));
            if (q.size() != 0) void'(q.pop_front());
        end
        chk("t2_cnt", 32'(words_sent), 32'd3);

        // 3: all four ports non-empty, rotation from p0
        init = 1'b1; step();
        init = 1'b0; step();
        empty_p = 4'h0;
        data_in0 = 10'h000; data_in1 = 10'h101; data_in2 = 10'h202; data_in3 = 10'h303;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_order", 32'(pop_p), 32'd1 << (i % 4));
            step();
        end

        // 4: almost-full after a pop; in-flight word still pushed
        almostfull_p = 4'b0010;
        #1;
        chk("t4_inflight", 32'(push_p != 4'b0000), 32'd1);
        step();
        step();
        almostfull_p = 4'b0000;
        #1;
        chk("t4_resume", 32'(pop_p), 32'b0010);
        step();

        // 5: init while a word is in flight
        init = 1'b1;
        #1;
        chk("t5_nopop", 32'(pop_p), 32'd0);
        chk("t5_push",  32'(push_p != 4'b0000), 32'd1);
        step();
        step();
        chk("t5_state", 32'(state),      32'd1);
        chk("t5_cnt",   32'(words_sent), 32'd0);
        init = 1'b0;
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            init         = ($urandom_range(0, 31) == 0);
            empty_p      = 4'($urandom);
            almostfull_p = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            data_in0 = 10'($urandom); data_in1 = 10'($urandom);
            data_in2 = 10'($urandom); data_in3 = 10'($urandom);
            step();
        end

        // 6: counter wrap, then reset mid-burst
        do_reset();
        init = 1'b0; empty_p = 4'hF; almostfull_p = 4'h0;
        step();
        step();
        empty_p = 4'b1110;
        while (m_cnt != 16'hFFFF) begin
            data_in0 = 10'($urandom);
            step();
        end
        chk("t6_max", 32'(words_sent), 32'h0000FFFF);
        step();
        chk("t6_wrap0", 32'(words_sent), 32'h00000000);
        step();
        chk("t6_wrap1", 32'(words_sent), 32'h00000001);
        chk("t6_pending", 32'(push_p != 4'b0000), 32'd1);
        do_reset();
        init = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
